// File: rtl/beam_thresh_loader.sv
// Per-beam threshold shadow buffer. It is filled with defaults after reset and
// updated by the host. On commit it is streamed into the beamformer shift chain.
module beam_thresh_loader #(
    parameter int               NBEAMS         = 48,
    parameter int               TBITS          = 18,
    parameter logic [TBITS-1:0] DEFAULT_THRESH = TBITS'(4000)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      wr_i,
    input  logic [$clog2(NBEAMS)-1:0] wr_beam_i,
    input  logic                      wr_set_i,
    input  logic [TBITS-1:0]          wr_dat_i,
    output logic                      wr_ack_o,
    output logic                      wr_err_o,
    input  logic                      commit_i,
    input  logic [1:0]                commit_mask_i,
    output logic                      busy_o,
    output logic [2*TBITS-1:0]        thresh_o,
    output logic [1:0]                thresh_wr_o,
    output logic [1:0]                thresh_update_o
);
    localparam int ABITS = $clog2(NBEAMS);
    localparam logic [ABITS-1:0] LAST = ABITS'(NBEAMS - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOAD, S_DRAIN, S_UPDATE} state_t;

    state_t           state, state_n;
    logic [ABITS-1:0] cnt, cnt_n;
    logic [1:0]       mask, mask_n, pmask, pmask_n;
    logic             pend, pend_n;
    logic             we0, we1, ack_n, err_n;
    logic [ABITS-1:0] waddr;
    logic [TBITS-1:0] wdat0, wdat1;
    logic             commit_go;

    // Each set is kept as its own array, so a host write touches only one half.
    logic [TBITS-1:0] mem0 [NBEAMS];
    logic [TBITS-1:0] mem1 [NBEAMS];

    assign commit_go = commit_i && (commit_mask_i != 2'b00);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mask_n  = mask;
        pend_n  = pend;
        pmask_n = pmask;
        we0     = 1'b0;
        we1     = 1'b0;
        waddr   = cnt;
        wdat0   = DEFAULT_THRESH;
        wdat1   = DEFAULT_THRESH;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        case (state)
            S_INIT: begin
                we0   = 1'b1;
                we1   = 1'b1;
                cnt_n = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            end
            S_IDLE, S_UPDATE: begin
                // A commit outranks a host write, and a pending commit outranks both.
                // This lets back-to-back loads chain without an IDLE gap.
                if (pend || commit_go) begin
                    state_n = S_LOAD;
                    cnt_n   = LAST;
                    mask_n  = pmask | (commit_go ? commit_mask_i : 2'b00);
                    pend_n  = 1'b0;
                    pmask_n = 2'b00;
                end else if (state == S_UPDATE) begin
                    state_n = S_IDLE;
                end else if (wr_i && !wr_ack_o) begin
                    ack_n = 1'b1;
                    if (int'(wr_beam_i) >= NBEAMS) begin
                        err_n = 1'b1;
                    end else begin
                        waddr = wr_beam_i;
                        wdat0 = wr_dat_i;
                        wdat1 = wr_dat_i;
                        we0   = !wr_set_i;
                        we1   = wr_set_i;
                    end
                end
            end
            S_LOAD: begin
                cnt_n = cnt - 1'b1;
                if (cnt == '0) state_n = S_DRAIN;
            end
            S_DRAIN: state_n = S_UPDATE;
            default: state_n = S_INIT;
        endcase
        if (commit_go && (state == S_INIT || state == S_LOAD || state == S_DRAIN)) begin
            pend_n  = 1'b1;
            pmask_n = pmask | commit_mask_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_INIT;
            cnt   <= '0;
            mask  <= 2'b00;
            pend  <= 1'b0;
            pmask <= 2'b00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            mask  <= mask_n;
            pend  <= pend_n;
            pmask <= pmask_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we0) mem0[waddr] <= wdat0;
        if (we1) mem1[waddr] <= wdat1;
    end

    // The registered read doubles as the output stage, one cycle behind the read address.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            thresh_o    <= '0;
            thresh_wr_o <= 2'b00;
            wr_ack_o    <= 1'b0;
            wr_err_o    <= 1'b0;
        end else begin
            wr_ack_o    <= ack_n;
            wr_err_o    <= err_n;
            thresh_wr_o <= (state == S_LOAD) ? mask : 2'b00;
            if (state == S_LOAD) thresh_o <= {mem1[cnt], mem0[cnt]};
        end
    end

    assign thresh_update_o = (state == S_UPDATE) ? mask : 2'b00;
    assign busy_o          = (state != S_IDLE) || pend;

endmodule

// File: doc/beam_thresh_loader.md
Name: beam_thresh_loader

Overview:
Controller that owns the per-beam trigger thresholds of the beamformer and sequences them into its threshold shift chain. The host writes thresholds into a local shadow buffer of NBEAMS x 2 x 18-bit entries. On a commit, the block streams the buffer into the beamformer via thresh/thresh_wr, then issues a single thresh_update pulse so all beams switch together. It sits between the register interface and the beamformer trigger in the clk_i domain.

Parameters:
NBEAMS, 48, number of beams; depth of the shadow buffer and length of one load sequence.
TBITS, 18, threshold width per set.
DEFAULT_THRESH, 18'd4000, value written to every entry by the post-reset init sweep.
ABITS (localparam), $clog2(NBEAMS), beam address width.

Ports:
clk_i  in  1  trigger clock.
rst_n_i  in  1  reset, asynchronous assert, active-low.
wr_i  in  1  host write strobe, single cycle, held until wr_ack_o.
wr_beam_i  in  ABITS  beam index.
wr_set_i  in  1  threshold set select (0 or 1).
wr_dat_i  in  TBITS  threshold value.
wr_ack_o  out  1  one-cycle write acknowledge.
wr_err_o  out  1  qualifies wr_ack_o: beam index >= NBEAMS, no write performed.
commit_i  in  1  commit request, single-cycle pulse.
commit_mask_i  in  2  sets to load and update, sampled with commit_i.
busy_o  out  1  high during INIT, LOAD, UPDATE, or while a commit is pending.
thresh_o  out  2*TBITS  {set1, set0} threshold data to the beamformer.
thresh_wr_o  out  2  per-set shift-in enable.
thresh_update_o  out  2  per-set update pulse.

Behaviour:
- Reset values: all outputs 0, except busy_o = 1. FSM enters INIT.
- Shadow buffer: NBEAMS x 2*TBITS storage with one synchronous write port and one read port. Read latency is 1 cycle. Contents are not reset.
- INIT: write {DEFAULT_THRESH, DEFAULT_THRESH} to beams 0..NBEAMS-1, one per cycle. Go to IDLE after beam NBEAMS-1. busy_o drops the cycle IDLE is entered.
- Host write:
  - Accepted only in IDLE.
  - wr_ack_o pulses exactly 1 cycle after acceptance, then wr_i must drop. Only the selected 18-bit half of the entry is modified.
  - In any other state wr_i is held off with no ack. It is serviced on the first IDLE cycle.
  - wr_beam_i >= NBEAMS: ack with wr_err_o = 1, buffer unchanged.
- Commit:
  - commit_i in IDLE with commit_mask_i != 0: latch the mask and enter LOAD next cycle.
  - mask == 0: ignored; no LOAD and no update pulse.
- LOAD:
  - A read counter runs from NBEAMS-1 down to 0, one beam per cycle, so beam 0 is shifted in last.
  - Cycle timing: commit sampled at edge 0. Read address NBEAMS-1 is presented in cycle 1, and its data appears on thresh_o with thresh_wr_o = mask in cycle 2.
  - thresh_wr_o = mask for exactly NBEAMS consecutive cycles (cycles 2..NBEAMS+1), then returns to 0.
- UPDATE:
  - In cycle NBEAMS+2, thresh_update_o = mask for exactly 1 cycle, with thresh_wr_o = 0.
  - Back to IDLE in cycle NBEAMS+3; busy_o falls then if no commit is pending.
- thresh_o is undefined-but-stable (last value held) whenever thresh_wr_o = 0.
- Commit during INIT/LOAD/UPDATE: set a pending flag and OR the mask into a pending mask. Start a new LOAD directly from UPDATE, with no IDLE cycle and no host write in between. Multiple commits while busy collapse into one.
- Simultaneous wr_i and commit_i in IDLE: the commit wins. The write is serviced after the sequence completes, so it is not included in that load.
- Reset mid-sequence:
  - All outputs drop immediately (async).
  - Pending commit cleared; INIT re-runs.
  - The beamformer sees a truncated shift with no update pulse, so its active thresholds stay unchanged.

Test Plan:
- Reset release: busy_o high for NBEAMS+1 cycles max. Commit mask 2'b11 afterwards streams 48 words, all {18'd4000, 18'd4000}. thresh_wr_o = 2'b11 for 48 cycles, then thresh_update_o = 2'b11 for one cycle.
- Write beam 5 set 0 = 18'd1234 and beam 5 set 1 = 18'd777, then commit mask 2'b01: the 43rd streamed word (beam 5) = {18'd777, 18'd1234}, thresh_wr_o = 2'b01, update pulse 2'b01 only.
- wr_beam_i = 50 (NBEAMS = 48): wr_ack_o and wr_err_o both pulse together. A subsequent commit streams unchanged data.
- Commit at LOAD cycle 10 with mask 2'b10 during a 2'b01 load: the first update is 2'b01. A second 48-word load with mask 2'b10 starts the cycle after it; busy_o stays high throughout.
- wr_i asserted in LOAD: no ack until IDLE, ack arrives 1 cycle after IDLE entry. Write is applied to the buffer and absent from the in-flight stream.
- rst_n_i low at LOAD cycle 20: thresh_wr_o = 0 and thresh_update_o = 0 immediately, with no update pulse. After release, INIT re-runs and busy_o stays high for NBEAMS+1 cycles max.
